// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed active-low 7-segment bus.
// Debounces each digit slot, decodes it to BCD and publishes full snapshots.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_done,
  output logic                  err_out
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic {TRACK, LOCKED} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [6:0]            seg_q;
  logic [DIGITS-1:0]     an_q;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIGITS-1:0]     svld_q, svld_d;
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic [4*DIGITS-1:0]   value_q, value_d;
  logic [DIGITS-1:0]     dvld_q, dvld_d;
  logic                  frame_q, frame_d;
  logic                  err_q, err_d;

  logic                  match;
  logic                  onehot;
  logic                  commit;
  logic [DIGITS-1:0]     anl;
  logic [3:0]            dec_nib;
  logic                  dec_vld;
  logic                  dec_err;
  logic                  unused_dp;

  assign unused_dp = seg_in[7];
  assign anl = ~an_q;
  assign onehot = (anl != '0) &&
                  ((anl & (anl - DIGITS'(1))) == '0);
  assign match = (seg_in[6:0] == seg_q) && (an_in == an_q);

  // Inverse of the encoder table; blank maps to F, anything else to E
  always_comb begin
    dec_nib = 4'hE;
    case (seg_q)
      7'h40: dec_nib = 4'h0;
      7'h79: dec_nib = 4'h1;
      7'h24: dec_nib = 4'h2;
      7'h30: dec_nib = 4'h3;
      7'h19: dec_nib = 4'h4;
      7'h12: dec_nib = 4'h5;
      7'h02: dec_nib = 4'h6;
      7'h78: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h10: dec_nib = 4'h9;
      7'h7F: dec_nib = 4'hF;
      default: dec_nib = 4'hE;
    endcase
    dec_vld = (dec_nib <= 4'h9);
    dec_err = (dec_nib == 4'hE);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (!match) begin
      cnt_d   = '0;
      state_d = TRACK;
    end else begin
      if (cnt_q != CMAX) cnt_d = cnt_q + CW'(1);
      if (state_q == TRACK && cnt_q == CMAX && onehot) begin
        commit  = 1'b1;
        state_d = LOCKED;
      end
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    svld_d   = svld_q;
    seen_d   = seen_q;
    value_d  = value_q;
    dvld_d   = dvld_q;
    frame_d  = 1'b0;
    err_d    = err_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (commit && !an_q[i]) begin
        shadow_d[4*i +: 4] = dec_nib;
        svld_d[i]          = dec_vld;
        seen_d[i]          = 1'b1;
      end
    end
    // The completing digit is published in the same cycle it is committed
    if (commit && (&seen_d)) begin
      value_d = shadow_d;
      dvld_d  = svld_d;
      frame_d = 1'b1;
      seen_d  = '0;
    end
    if (commit && dec_err) err_d = 1'b1;
    else if (err_clr)      err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TRACK;
      cnt_q    <= '0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
      shadow_q <= '1;
      svld_q   <= '0;
      seen_q   <= '0;
      value_q  <= '1;
      dvld_q   <= '0;
      frame_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seg_q    <= seg_in[6:0];
      an_q     <= an_in;
      shadow_q <= shadow_d;
      svld_q   <= svld_d;
      seen_q   <= seen_d;
      value_q  <= value_d;
      dvld_q   <= dvld_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
    end
  end

  assign value_out   = value_q;
  assign digit_valid = dvld_q;
  assign frame_done  = frame_q;
  assign err_out     = err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: expected frames are queued
// when the completing digit is driven and checked on frame_done.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = 8'hFF;
  logic [3:0]  an_in = 4'hF;
  logic        err_clr = 1'b0;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        err_out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] v;
    logic [3:0]  d;
    int          c;
  } exp_t;

  exp_t q[$];

  logic [6:0] ENC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(S)) dut (
    .clk(clk),
    .rst(rst),
    .seg_in(seg_in),
    .an_in(an_in),
    .err_clr(err_clr),
    .value_out(value_out),
    .digit_valid(digit_valid),
    .frame_done(frame_done),
    .err_out(err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_frame", 32'(frame_done), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("frame_value", 32'(value_out), 32'(e.v));
        chk("frame_valid", 32'(digit_valid), 32'(e.d));
        chk("frame_cycle", 32'(cyc), 32'(e.c));
      end
    end
  end

  // Raw 7-bit code on one anode pattern for n edges; optionally expect a frame
  task automatic hold(input logic [6:0] code, input logic [3:0] a,
                      input int n, input bit fr,
                      input logic [15:0] ev, input logic [3:0] ed);
    exp_t e;
    @(negedge clk);
    seg_in = {1'b1, code};
    an_in  = a;
    if (fr) begin
      e.v = ev;
      e.d = ed;
      e.c = cyc + 1 + S;
      q.push_back(e);
    end
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int c0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_value", 32'(value_out), 32'hFFFF);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_frame", 32'(frame_done), 32'h0);
    chk("rst_err", 32'(err_out), 32'h0);
    rst = 1'b0;

    hold(ENC[4], 4'b1110, 8, 0, 0, 0);
    hold(ENC[3], 4'b1101, 8, 0, 0, 0);
    hold(ENC[2], 4'b1011, 8, 0, 0, 0);
    hold(ENC[1], 4'b0111, 8, 1, 16'h1234, 4'hF);

    hold(ENC[5], 4'b0111, 8, 0, 0, 0);
    hold(ENC[6], 4'b1011, 8, 0, 0, 0);
    hold(ENC[7], 4'b1101, 8, 0, 0, 0);
    hold(ENC[9], 4'b1110, 3, 0, 0, 0);
    hold(ENC[1], 4'b1110, 1, 0, 0, 0);
    hold(ENC[9], 4'b1110, 8, 1, 16'h5679, 4'hF);

    hold(ENC[8], 4'b1110, 8, 0, 0, 0);
    hold(7'h55,  4'b1101, 8, 0, 0, 0);
    hold(7'h7F,  4'b1011, 8, 0, 0, 0);
    hold(ENC[0], 4'b0111, 8, 1, 16'h0FE8, 4'b1001);
    chk("err_set", 32'(err_out), 32'h1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 32'(err_out), 32'h0);

    @(negedge clk);
    seg_in = {1'b1, 7'h55};
    an_in  = 4'b1101;
    c0 = cyc;
    repeat (S) @(posedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_set_wins", 32'(err_out), 32'h1);
    chk("err_set_cycle", 32'(cyc), 32'(c0 + S + 1));
    repeat (3) @(posedge clk);

    hold(ENC[8], 4'b1111, 20, 0, 0, 0);
    hold(ENC[8], 4'b1100, 20, 0, 0, 0);
    hold(ENC[1], 4'b1110, 8, 0, 0, 0);
    hold(ENC[2], 4'b1011, 8, 0, 0, 0);
    hold(ENC[3], 4'b0111, 30, 1, 16'h32E1, 4'b1101);

    hold(ENC[4], 4'b1110, 8, 0, 0, 0);
    hold(ENC[4], 4'b1101, 8, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_value", 32'(value_out), 32'hFFFF);
    chk("rst2_valid", 32'(digit_valid), 32'h0);
    chk("rst2_err", 32'(err_out), 32'h0);
    hold(ENC[7], 4'b1011, 8, 0, 0, 0);
    hold(ENC[6], 4'b0111, 8, 0, 0, 0);
    hold(ENC[9], 4'b1110, 8, 0, 0, 0);
    hold(ENC[8], 4'b1101, 8, 1, 16'h6789, 4'hF);
    repeat (4) @(posedge clk);

    chk("pending_frames", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Reverse path of the display encoder. The block samples the multiplexed 7-segment bus (active-low segment code plus active-low digit-select anodes) and debounces each digit slot. It decodes every stable code back to a BCD nibble and publishes a complete multi-digit snapshot once every digit has been seen. It is used as a display readback monitor for self-check and on-board verification of the counter/encoder path.

## Interface
- DIGITS, 4: number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (2..255).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- seg_in  in  8  segment bus, active-low; bit7 = dp (ignored), bits6:0 = g..a.
- an_in  in  DIGITS  digit select, active-low; exactly one bit low selects a digit.
- err_clr  in  1  clears err_out (synchronous, one-cycle pulse).
- value_out  out  4*DIGITS  snapshot; nibble i = digit i (bits 4i+3:4i).
- digit_valid  out  DIGITS  bit i = 1 when snapshot nibble i decoded from a numeral 0-9.
- frame_done  out  1  one-cycle pulse when value_out/digit_valid update.
- err_out  out  1  sticky flag: an unrecognised code was committed.

## Operation
- Input stage: seg_in/an_in registered into seg_q/an_q every cycle (1-cycle latency).
- Match: pair (seg_in[6:0], an_in) compared to (seg_q[6:0], an_q); mismatch -> cnt <= 0, state <= TRACK; match -> cnt increments, saturating at STABLE_CYCLES-1.
- FSM, 2 states:
  - TRACK: when cnt == STABLE_CYCLES-1 and an_q is exactly one-hot-low -> commit, state <= LOCKED. If an_q is not one-hot (all high, or multiple low) -> no commit, stay TRACK.
  - LOCKED: no further commits; any input change -> TRACK, cnt <= 0.
- Decode of seg_q[6:0] (inverse of the encoder table): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9 (hex, 7-bit). These give nibble = digit, valid = 1.
- 7F (all off) -> nibble F, valid 0, not an error.
- Any other code -> nibble E, valid 0, err_out <= 1.
- Commit writes nibble/valid into shadow slot i (i = index of the low an_q bit) and sets seen[i].
- Frame: on the commit that makes seen all-ones, value_out/digit_valid <= shadow (including the nibble committed that cycle), frame_done = 1, seen <= 0. Otherwise frame_done = 0.
- A digit re-committed before the frame completes overwrites its shadow slot; the latest value wins.
- err_clr and a simultaneous error commit: the set wins, err_out stays 1.
- Reset values: value_out all nibbles F, digit_valid 0, frame_done 0, err_out 0, seen 0, shadow all F/invalid, cnt 0, seg_q 7F+dp=FF, an_q all-ones, state TRACK.
- Reset mid-frame discards the partial frame. The first frame after reset needs every digit committed again.

## Timing
- Inputs held constant from before edge E0: seg_q/an_q loaded at E0 (cnt 0), cnt reaches STABLE_CYCLES-1 at edge E0+STABLE_CYCLES-1. The commit occurs at E0+STABLE_CYCLES, where shadow, seen, err_out and (last digit) value_out/frame_done are all registered.
- Default parameters: commit 4 cycles after the first stable edge; frame_done high for exactly one cycle.
- A glitch of even one cycle restarts the count; a digit slot held for fewer than STABLE_CYCLES+1 edges is never committed.
- Exactly one commit per stable interval, regardless of how long the interval lasts.
- cnt width = clog2(STABLE_CYCLES); saturating, never wraps.

## Test plan
- Reset: rst high 2 cycles -> value_out FFFF, digit_valid 0, frame_done 0, err_out 0.
- Scan "1234" (an 1110/C0-encoded 4, 1101/3, 1011/2, 0111/1, 8 cycles each) -> single frame_done after the 4th digit commit; value_out 1234 hex, digit_valid 1111.
- Glitch: digit 0 held 3 cycles, 1-cycle seg change, then held 8 -> commit exactly STABLE_CYCLES+1 edges after the glitch ends; no commit from the first 3-cycle run.
- Blank and illegal codes: digit 2 = 7F, digit 1 = 55 -> nibbles F and E, digit_valid bits 0, err_out 1. err_clr then clears it; err_clr coincident with another 55 commit keeps it 1.
- Non-one-hot anodes: an_in 1111 or 1100 held 20 cycles -> no commit, seen unchanged, frame_done 0.
- rst asserted after 2 of 4 digits committed, then a full scan -> first frame_done only after all 4 digits are re-committed; value_out reflects the new scan only.
